// File: rtl/fp_pkg.sv
// ----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the FPU operand/result sequencing logic.
//   - FPU op codes driven on the FPU's in_FPU_Op input (0000..0111 legal).
//   - Format selects for the FPU's in_fmt input.
//   - Sequencer FSM state encoding.
//   - Small elaboration-time helpers used to size the latency and counter
//     fields from the latency parameters.
// ----------------------------------------------------------------------------
package fp_pkg;

  // FPU operation codes. Anything with bit 3 set is not an FPU operation.
  localparam logic [3:0] FPU_OP_ADDSUB = 4'b0000;
  localparam logic [3:0] FPU_OP_MUL    = 4'b0001;
  localparam logic [3:0] FPU_OP_DIV    = 4'b0010;
  localparam logic [3:0] FPU_OP_MINMAX = 4'b0011;
  localparam logic [3:0] FPU_OP_CMP    = 4'b0100;
  localparam logic [3:0] FPU_OP_SGNJ   = 4'b0101;
  localparam logic [3:0] FPU_OP_CVT    = 4'b0110;
  localparam logic [3:0] FPU_OP_INTCVT = 4'b0111;

  // Operand format.
  localparam logic FMT_S = 1'b0;
  localparam logic FMT_D = 1'b1;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

  // Largest of four latencies; sizes the down-counter.
  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Bits needed to hold values 0..v-1, never less than one bit so that a
  // design where every op is single-cycle still elaborates a counter.
  function automatic int width_for(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/fp_op_latency.sv
// ----------------------------------------------------------------------------
// fp_op_latency
// Combinational op-code decode: returns how many cycles the FPU needs for an
// op and whether the op code is illegal. Pure lookup so that other blocks
// (e.g. hazard/scoreboard logic) can reuse the same table.
//
// Ports
//   in_op        in   4      FPU op code
//   out_latency  out  LAT_W  FPU latency in cycles (0 when illegal)
//   out_illegal  out  1      op code is 1000..1111
// ----------------------------------------------------------------------------
module fp_op_latency #(
  parameter int LAT_ADDSUB = 3,
  parameter int LAT_MUL    = 4,
  parameter int LAT_DIV    = 16,
  parameter int LAT_MISC   = 1,
  parameter int LAT_W      = 5
) (
  input  logic [3:0]       in_op,
  output logic [LAT_W-1:0] out_latency,
  output logic             out_illegal
);

  import fp_pkg::*;

  always_comb begin
    out_latency = '0;
    out_illegal = 1'b0;
    case (in_op)
      FPU_OP_ADDSUB: out_latency = LAT_W'(LAT_ADDSUB);
      FPU_OP_MUL:    out_latency = LAT_W'(LAT_MUL);
      FPU_OP_DIV:    out_latency = LAT_W'(LAT_DIV);
      // min/max, compare, sign-inject and both conversions share one latency.
      FPU_OP_MINMAX,
      FPU_OP_CMP,
      FPU_OP_SGNJ,
      FPU_OP_CVT,
      FPU_OP_INTCVT: out_latency = LAT_W'(LAT_MISC);
      default:       out_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fp_op_sequencer.sv
// ----------------------------------------------------------------------------
// fp_op_sequencer
// Initiator side of the FPU operand/result interface. Takes one request at a
// time from issue, drives the combinational FPU with registered operands for
// the op's latency, captures the FPU output and presents it with its tag on a
// valid/ready response port towards writeback.
//
// Ports
//   in_clk           in   1           clock (rising edge)
//   in_rst_n         in   1           asynchronous reset, active low
//   in_req_valid     in   1           request valid
//   out_req_ready    out  1           request ready
//   in_req_op        in   4           FPU op code
//   in_req_fmt       in   1           0 = single, 1 = double
//   in_req_rs1/rs2   in   DATA_WIDTH  operands
//   in_req_tag       in   TAG_WIDTH   tag returned with the result
//   in_flush         in   1           kill in-flight op / pending response
//   out_fpu_op/fmt/rs1/rs2  out       registered operands to the FPU
//   in_fpu_result    in   DATA_WIDTH  FPU output
//   out_rsp_valid    out  1           response valid
//   in_rsp_ready     in   1           response ready
//   out_rsp_data     out  DATA_WIDTH  captured result (0 for illegal op)
//   out_rsp_tag      out  TAG_WIDTH   tag of the request
//   out_rsp_illegal  out  1           op code was illegal
//
// Timing: a legal op of latency L accepted on edge T is captured on edge T+L
// (the FPU inputs have then been stable for L full cycles); an illegal op
// goes straight to the response state on the accept edge.
// ----------------------------------------------------------------------------
module fp_op_sequencer
  import fp_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 5,
  parameter int LAT_ADDSUB = 3,
  parameter int LAT_MUL    = 4,
  parameter int LAT_DIV    = 16,
  parameter int LAT_MISC   = 1
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  // request from issue
  input  logic                  in_req_valid,
  output logic                  out_req_ready,
  input  logic [3:0]            in_req_op,
  input  logic                  in_req_fmt,
  input  logic [DATA_WIDTH-1:0] in_req_rs1,
  input  logic [DATA_WIDTH-1:0] in_req_rs2,
  input  logic [TAG_WIDTH-1:0]  in_req_tag,
  input  logic                  in_flush,
  // FPU operand/result interface
  output logic [3:0]            out_fpu_op,
  output logic                  out_fpu_fmt,
  output logic [DATA_WIDTH-1:0] out_fpu_rs1,
  output logic [DATA_WIDTH-1:0] out_fpu_rs2,
  input  logic [DATA_WIDTH-1:0] in_fpu_result,
  // response to writeback
  output logic                  out_rsp_valid,
  input  logic                  in_rsp_ready,
  output logic [DATA_WIDTH-1:0] out_rsp_data,
  output logic [TAG_WIDTH-1:0]  out_rsp_tag,
  output logic                  out_rsp_illegal
);

  localparam int MAX_LAT = max_of4(LAT_ADDSUB, LAT_MUL, LAT_DIV, LAT_MISC);
  localparam int LAT_W   = width_for(MAX_LAT + 1);
  localparam int CNT_W   = width_for(MAX_LAT);

  // --------------------------------------------------------------------------
  // Op decode
  // --------------------------------------------------------------------------
  logic [LAT_W-1:0] req_lat;
  logic             req_illegal;

  fp_op_latency #(
    .LAT_ADDSUB (LAT_ADDSUB),
    .LAT_MUL    (LAT_MUL),
    .LAT_DIV    (LAT_DIV),
    .LAT_MISC   (LAT_MISC),
    .LAT_W      (LAT_W)
  ) u_op_latency (
    .in_op       (in_req_op),
    .out_latency (req_lat),
    .out_illegal (req_illegal)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  seq_state_e            state_q,       state_d;
  logic [CNT_W-1:0]      cnt_q,         cnt_d;
  logic [3:0]            op_q,          op_d;
  logic                  fmt_q,         fmt_d;
  logic [DATA_WIDTH-1:0] rs1_q,         rs1_d;
  logic [DATA_WIDTH-1:0] rs2_q,         rs2_d;
  logic [TAG_WIDTH-1:0]  tag_q,         tag_d;
  logic                  rsp_valid_q,   rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q,    rsp_data_d;
  logic                  rsp_illegal_q, rsp_illegal_d;

  logic accept;

  // A new request can be taken when idle, or in the response state on the
  // same edge that the current response is consumed. Flush blocks it.
  assign out_req_ready = !in_flush &&
                         ((state_q == ST_IDLE) ||
                          ((state_q == ST_RESP) && in_rsp_ready));
  assign accept        = in_req_valid && out_req_ready;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    fmt_d         = fmt_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    tag_d         = tag_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_illegal_d = rsp_illegal_q;

    if (in_flush) begin
      // Killed op produces no response. Operand registers keep their value;
      // they only ever change on an accept.
      state_d     = ST_IDLE;
      rsp_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_EXEC: begin
          if (cnt_q == '0) begin
            rsp_data_d    = in_fpu_result;
            rsp_illegal_d = 1'b0;
            rsp_valid_d   = 1'b1;
            state_d       = ST_RESP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (in_rsp_ready) begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: ;
      endcase

      // Accept overrides the response-state exit above so a back-to-back
      // request goes straight to EXEC/RESP without an idle bubble.
      if (accept) begin
        op_d  = in_req_op;
        fmt_d = in_req_fmt;
        rs1_d = in_req_rs1;
        rs2_d = in_req_rs2;
        tag_d = in_req_tag;
        if (req_illegal) begin
          rsp_data_d    = '0;
          rsp_illegal_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else begin
          // Counter holds L-1 so the largest latency fits in CNT_W bits;
          // EXEC therefore lasts exactly L cycles.
          cnt_d   = CNT_W'(req_lat - LAT_W'(1));
          state_d = ST_EXEC;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      fmt_q         <= 1'b0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      tag_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      fmt_q         <= fmt_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      tag_q         <= tag_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out_fpu_op      = op_q;
  assign out_fpu_fmt     = fmt_q;
  assign out_fpu_rs1     = rs1_q;
  assign out_fpu_rs2     = rs2_q;
  assign out_rsp_valid   = rsp_valid_q;
  assign out_rsp_data    = rsp_data_q;
  // The request tag register is only rewritten on accept, which cannot
  // happen before the previous response has been consumed.
  assign out_rsp_tag     = tag_q;
  assign out_rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_fp_op_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fp_op_sequencer
// Scoreboard bench: the driver pushes the expected response (data, tag,
// illegal flag, first cycle it should be visible) when a request is accepted;
// an independent monitor compares the DUT against the queue every cycle.
// The FPU is a behavioural stand-in whose output is only meaningful once its
// inputs have been stable for the op's latency.
// ----------------------------------------------------------------------------
module tb_fp_op_sequencer;

  localparam int DW = 64;
  localparam int TW = 5;
  localparam logic [63:0] POISON = 64'hBADB_ADBA_DBAD_BAD0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_op = '0;
  logic          req_fmt = 1'b0;
  logic [DW-1:0] req_rs1 = '0;
  logic [DW-1:0] req_rs2 = '0;
  logic [TW-1:0] req_tag = '0;
  logic          flush = 1'b0;
  logic [3:0]    fpu_op;
  logic          fpu_fmt;
  logic [DW-1:0] fpu_rs1, fpu_rs2, fpu_result;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          rsp_illegal;

  always #5 clk = ~clk;

  fp_op_sequencer #(
    .DATA_WIDTH(DW), .TAG_WIDTH(TW),
    .LAT_ADDSUB(3), .LAT_MUL(4), .LAT_DIV(16), .LAT_MISC(1)
  ) dut (
    .in_clk(clk), .in_rst_n(rst_n),
    .in_req_valid(req_valid), .out_req_ready(req_ready),
    .in_req_op(req_op), .in_req_fmt(req_fmt),
    .in_req_rs1(req_rs1), .in_req_rs2(req_rs2), .in_req_tag(req_tag),
    .in_flush(flush),
    .out_fpu_op(fpu_op), .out_fpu_fmt(fpu_fmt),
    .out_fpu_rs1(fpu_rs1), .out_fpu_rs2(fpu_rs2), .in_fpu_result(fpu_result),
    .out_rsp_valid(rsp_valid), .in_rsp_ready(rsp_ready),
    .out_rsp_data(rsp_data), .out_rsp_tag(rsp_tag), .out_rsp_illegal(rsp_illegal)
  );

  // ---------------- reference model ----------------
  function automatic int lat_of(input logic [3:0] op);
    case (op)
      4'd0:    return 3;
      4'd1:    return 4;
      4'd2:    return 16;
      default: return (op < 4'd8) ? 1 : 0;
    endcase
  endfunction

  function automatic logic [63:0] fpu_func(input logic [3:0] op, input logic fmt,
                                           input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    case (op)
      4'd0:    r = fmt ? $realtobits($bitstoreal(a) + $bitstoreal(b)) : a + b;
      4'd1:    r = a * b;
      4'd2:    r = a / (b | 64'd1);
      4'd3:    r = (a < b) ? a : b;
      4'd4:    r = {63'd0, a == b};
      4'd5:    r = a ^ b;
      4'd6:    r = ~a;
      4'd7:    r = {a[31:0], b[31:0]};
      default: r = POISON;
    endcase
    if (op != 4'd0) r = r ^ {56'd0, fmt, 7'd0};
    return r;
  endfunction

  // Behavioural FPU: result valid only after inputs held for the op latency.
  int age = 0;
  logic [4+1+2*DW-1:0] prev_in = '0;
  initial forever begin
    @(negedge clk);
    if ({fpu_op, fpu_fmt, fpu_rs1, fpu_rs2} !== prev_in) begin
      prev_in = {fpu_op, fpu_fmt, fpu_rs1, fpu_rs2};
      age = 0;
    end else begin
      age = age + 1;
    end
  end
  assign fpu_result = (age >= lat_of(fpu_op) - 1) ?
                      fpu_func(fpu_op, fpu_fmt, fpu_rs1, fpu_rs2) : POISON;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic          illegal;
    longint        due;
  } exp_t;

  exp_t          sb_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  longint        cyc = 0;
  logic [3:0]    last_op = '0;
  logic          last_fmt = 1'b0;
  logic [DW-1:0] last_rs1 = '0, last_rs2 = '0;
  logic          m_vis, m_rdy;
  bit            rand_rdy = 0, rand_flush = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares DUT against the model state every cycle.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      m_vis = (sb_q.size() > 0) && (cyc >= sb_q[0].due);
      m_rdy = !flush && ((sb_q.size() == 0) || (m_vis && rsp_ready));
      check("rsp_valid", 64'(rsp_valid), 64'(m_vis));
      check("req_ready", 64'(req_ready), 64'(m_rdy));
      check("fpu_op",  64'(fpu_op),  64'(last_op));
      check("fpu_fmt", 64'(fpu_fmt), 64'(last_fmt));
      check("fpu_rs1", fpu_rs1, last_rs1);
      check("fpu_rs2", fpu_rs2, last_rs2);
      if (m_vis) begin
        check("rsp_data",    rsp_data,          sb_q[0].data);
        check("rsp_tag",     64'(rsp_tag),      64'(sb_q[0].tag));
        check("rsp_illegal", 64'(rsp_illegal),  64'(sb_q[0].illegal));
      end
      if (flush) begin
        sb_q.delete();
      end else if (m_vis && rsp_ready) begin
        $display("rsp  tag=%0d data=%h illegal=%0b cycle=%0d",
                 sb_q[0].tag, sb_q[0].data, sb_q[0].illegal, cyc);
        void'(sb_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick(output bit acc);
    exp_t e;
    acc = 0;
    @(negedge clk);
    #1;
    if (rst_n && req_valid && req_ready) begin
      acc       = 1;
      e.illegal = req_op[3];
      e.data    = req_op[3] ? '0 : fpu_func(req_op, req_fmt, req_rs1, req_rs2);
      e.tag     = req_tag;
      e.due     = cyc + 1 + lat_of(req_op);
      sb_q.push_back(e);
      last_op  = req_op;
      last_fmt = req_fmt;
      last_rs1 = req_rs1;
      last_rs2 = req_rs2;
    end
    @(posedge clk);
    #1;
    if (rand_rdy)   rsp_ready = ($urandom_range(0, 3) != 0);
    if (rand_flush) flush     = ($urandom_range(0, 24) == 0);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) tick(a);
  endtask

  task automatic send(input logic [3:0] op, input logic fmt, input logic [63:0] a,
                      input logic [63:0] b, input logic [TW-1:0] tag);
    bit acc;
    int n;
    req_op = op; req_fmt = fmt; req_rs1 = a; req_rs2 = b; req_tag = tag;
    req_valid = 1'b1;
    acc = 0;
    n = 0;
    while (!acc && n < 200) begin
      tick(acc);
      n++;
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: tag %0d ready=%0b, required accept within 200 cycles", tag, req_ready);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_visible();
    int n = 0;
    while (!((sb_q.size() > 0) && (cyc >= sb_q[0].due)) && n < 200) begin
      idle(1);
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_visible: queue=%0d, required a due response within 200 cycles", sb_q.size());
    end
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb_q.size() > 0 && n < 200) begin
      idle(1);
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_empty: queue=%0d, required 0 within 200 cycles", sb_q.size());
    end
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [3:0] op;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_rsp_data",  rsp_data, 64'd0);
    check("reset_fpu_op",    64'(fpu_op), 64'd0);
    @(posedge clk); #1;

    // 1: double add 1.0 + 2.0
    send(4'd0, 1'b1, $realtobits(1.0), $realtobits(2.0), 5'd5);
    wait_visible();
    check("add_value", rsp_data, 64'h4008_0000_0000_0000);
    wait_empty();

    // 2: divide with writeback stalled for 10 cycles
    rsp_ready = 1'b0;
    send(4'd2, 1'b1, r64(), r64(), 5'd9);
    wait_visible();
    idle(10);
    rsp_ready = 1'b1;
    wait_empty();

    // 3: illegal op
    send(4'b1010, 1'b0, r64(), r64(), 5'd3);
    wait_empty();

    // 4: back-to-back handshake + accept in the response cycle
    rsp_ready = 1'b0;
    send(4'd0, 1'b0, r64(), r64(), 5'd7);
    wait_visible();
    rsp_ready = 1'b1;
    send(4'd5, 1'b1, r64(), r64(), 5'd8);
    wait_empty();

    // 5: flush at the 2nd EXEC cycle of a multiply, then flush during RESP
    send(4'd1, 1'b0, r64(), r64(), 5'd11);
    idle(1);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(8);
    rsp_ready = 1'b0;
    send(4'd3, 1'b1, r64(), r64(), 5'd12);
    wait_visible();
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(2);
    rsp_ready = 1'b1;

    // 6: asynchronous reset in the middle of a divide
    send(4'd2, 1'b0, r64(), r64(), 5'd13);
    idle(5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rsp_valid",   64'(rsp_valid),   64'd0);
    check("arst_rsp_data",    rsp_data,         64'd0);
    check("arst_rsp_tag",     64'(rsp_tag),     64'd0);
    check("arst_rsp_illegal", 64'(rsp_illegal), 64'd0);
    check("arst_fpu_op",      64'(fpu_op),      64'd0);
    check("arst_fpu_rs1",     fpu_rs1,          64'd0);
    sb_q.delete();
    last_op = '0; last_fmt = 1'b0; last_rs1 = '0; last_rs2 = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(4'd0, 1'b0, r64(), r64(), 5'd14);
    wait_empty();

    // randomized traffic with random back-pressure and flushes
    rand_rdy = 1;
    rand_flush = 1;
    for (int i = 0; i < 300; i++) begin
      idle($urandom_range(0, 2));
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      send(op, 1'($urandom_range(0, 1)), r64(), r64(), TW'($urandom_range(0, 31)));
    end
    rand_rdy = 0;
    rand_flush = 0;
    flush = 1'b0;
    rsp_ready = 1'b1;
    wait_empty();
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
